// File: rtl/supercar_pkg.sv
// supercar_pkg
// Shared definitions for the supercar LED bar sequencer: state encoding and
// default sizing (counter width, LED count, step prescaler).
package supercar_pkg;

  localparam int N_BIT_DEF = 4;
  localparam int N_LED_DEF = 16;
  localparam int PRESC_DEF = 25_000_000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_UP   = 2'd2;
  localparam logic [1:0] ST_DOWN = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    UP   = ST_UP,
    DOWN = ST_DOWN
  } state_e;

endpackage

// File: rtl/supercar_seq_tick_gen.sv
// tick_gen
// Step-rate prescaler. Emits a one-cycle tick every PRESC clocks while clr
// is low; clr restarts the period so the first tick after clr falls in the
// PRESC-th cycle.
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-high reset
//   clr   in  synchronous restart of the step period
//   tick  out one-cycle step pulse
module tick_gen
  import supercar_pkg::*;
#(
  parameter int PRESC = PRESC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [W-1:0] RELOAD = W'(PRESC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Down-counter: terminal count 0 is the tick, equivalent to an up-count
  // reaching PRESC-1. PRESC=1 leaves it pinned at 0, ticking every cycle.
  assign tick = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q - W'(1);
    if (clr || tick) begin
      cnt_d = RELOAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/supercar_seq.sv
// supercar_seq
// Bounces an external up/down/loadable position counter between both ends of
// an LED bar at a prescaled step rate and shows the position one-hot.
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  asynchronous active-high reset
//   start    in  run request, honoured only in IDLE
//   stop     in  halt request, any state, highest priority
//   cnt_in   in  position fed back from the counter
//   cnt_en   out counter enable
//   cnt_dnu  out counter direction (1 = down)
//   cnt_pl   out counter parallel-load strobe
//   cnt_pin  out counter load value
//   led      out one-hot position, registered
//   busy     out high whenever not IDLE
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | counter untouched, LEDs dark, waiting for start
// LOAD  | one cycle: load 0 into the counter
// UP    | stepping up on each tick, bounce at N_LED-1
// DOWN  | stepping down on each tick, bounce at 0
module supercar_seq
  import supercar_pkg::*;
#(
  parameter int N_BIT = N_BIT_DEF,
  parameter int N_LED = N_LED_DEF,
  parameter int PRESC = PRESC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [N_BIT-1:0] cnt_in,
  output logic             cnt_en,
  output logic             cnt_dnu,
  output logic             cnt_pl,
  output logic [N_BIT-1:0] cnt_pin,
  output logic [N_LED-1:0] led,
  output logic             busy
);

  localparam logic [N_BIT-1:0] LAST   = N_BIT'(N_LED - 1);
  // One bit wider so the range test stays meaningful when N_LED = 2^N_BIT.
  localparam logic [N_BIT:0]   LAST_X = (N_BIT + 1)'(N_LED - 1);
  localparam logic [N_LED-1:0] LED_ONE = N_LED'(1);

  state_e           state_q, state_d;
  logic [N_LED-1:0] led_q, led_d;
  logic             tick;
  logic             clr;
  logic             out_of_range;
  logic             at_top;
  logic             at_bottom;

  assign out_of_range = ({1'b0, cnt_in} > LAST_X);
  assign at_top       = (cnt_in == LAST);
  assign at_bottom    = (cnt_in == '0);

  assign clr = (state_q == IDLE) || (state_q == LOAD) || stop;

  tick_gen #(
    .PRESC(PRESC)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .tick(tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    cnt_dnu = 1'b0;
    cnt_pl  = 1'b0;
    cnt_pin = '0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_en  = 1'b1;
        cnt_pl  = 1'b1;
        state_d = UP;
      end
      UP: begin
        if (tick) begin
          cnt_en = 1'b1;
          if (out_of_range) begin
            cnt_pl  = 1'b1;
          end else if (at_top) begin
            cnt_dnu = 1'b1;
            state_d = DOWN;
          end
        end
      end
      DOWN: begin
        cnt_dnu = 1'b1;
        if (tick) begin
          cnt_en = 1'b1;
          if (out_of_range) begin
            cnt_pl  = 1'b1;
            state_d = UP;
          end else if (at_bottom) begin
            cnt_dnu = 1'b0;
            state_d = UP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Halt wins over everything; the counter is left holding its value.
    if (stop && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_en  = 1'b0;
      cnt_dnu = 1'b0;
      cnt_pl  = 1'b0;
      cnt_pin = '0;
    end
  end

  always_comb begin
    led_d = '0;
    if (((state_q == UP) || (state_q == DOWN)) && !out_of_range) begin
      led_d = LED_ONE << cnt_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
    end
  end

  assign led  = led_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_supercar_seq.sv
module tb_supercar_seq;

  localparam int N_BIT = 3;
  localparam int N_LED = 4;
  localparam int PRESC = 3;

  typedef struct {
    logic [N_BIT-1:0] pos;
    logic             dnu;
  } tick_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic [N_BIT-1:0] cnt_in;
  logic             cnt_en;
  logic             cnt_dnu;
  logic             cnt_pl;
  logic [N_BIT-1:0] cnt_pin;
  logic [N_LED-1:0] led;
  logic             busy;

  logic [N_BIT-1:0] cnt_m = '0;
  logic             force_req;
  logic [N_BIT-1:0] force_val;

  int checks = 0;
  int errors = 0;
  tick_t sb[$];

  supercar_seq #(
    .N_BIT(N_BIT),
    .N_LED(N_LED),
    .PRESC(PRESC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .cnt_in (cnt_in),
    .cnt_en (cnt_en),
    .cnt_dnu(cnt_dnu),
    .cnt_pl (cnt_pl),
    .cnt_pin(cnt_pin),
    .led    (led),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Behavioural up/down/loadable counter closing the loop.
  always @(posedge clk) begin
    if (force_req)    cnt_m <= force_val;
    else if (cnt_pl)  cnt_m <= cnt_pin;
    else if (cnt_en)  cnt_m <= cnt_dnu ? cnt_m - 1'b1 : cnt_m + 1'b1;
  end
  assign cnt_in = cnt_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits cycle by cycle (sampling 1 time unit after each falling edge)
  // until cnt_en is seen; returns the number of cycles waited.
  task automatic next_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!cnt_en && n < 20);
    chk("tick_timeout", 32'(n < 20), 32'd1);
  endtask

  task automatic run_sb(input string tag, input int first_gap);
    int n;
    tick_t e;
    logic [N_LED-1:0] led_exp;
    bit first;
    first = 1'b1;
    while (sb.size() > 0) begin
      next_tick(n);
      e = sb.pop_front();
      led_exp = 4'b0001 << e.pos;
      chk({tag, "_gap"}, n, first ? first_gap : PRESC);
      chk({tag, "_pos"}, cnt_in, e.pos);
      chk({tag, "_dnu"}, cnt_dnu, e.dnu);
      chk({tag, "_pl"}, cnt_pl, 1'b0);
      chk({tag, "_led"}, led, led_exp);
      first = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; stop = 1'b0; force_req = 1'b0; force_val = '0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_led", led, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_en", cnt_en, 1'b0);
    chk("rst_pl", cnt_pl, 1'b0);
    chk("rst_dnu", cnt_dnu, 1'b0);
    chk("rst_pin", cnt_pin, 3'd0);
    @(negedge clk); rst = 1'b0;

    // Start, LOAD cycle, full bounce
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    chk("load_en", cnt_en, 1'b1);
    chk("load_pl", cnt_pl, 1'b1);
    chk("load_pin", cnt_pin, 3'd0);
    chk("load_busy", busy, 1'b1);
    sb.push_back('{3'd0, 1'b0}); sb.push_back('{3'd1, 1'b0});
    sb.push_back('{3'd2, 1'b0}); sb.push_back('{3'd3, 1'b1});
    sb.push_back('{3'd2, 1'b1}); sb.push_back('{3'd1, 1'b1});
    sb.push_back('{3'd0, 1'b0}); sb.push_back('{3'd1, 1'b0});
    run_sb("run", PRESC);

    // Stop on the tick cycle at position 2
    @(negedge clk); #1;
    chk("between_en", cnt_en, 1'b0);
    @(negedge clk);
    @(negedge clk); stop = 1'b1; #1;
    chk("stop_pos", cnt_in, 3'd2);
    chk("stop_en", cnt_en, 1'b0);
    chk("stop_pl", cnt_pl, 1'b0);
    @(negedge clk); stop = 1'b0; #1;
    chk("stop_busy", busy, 1'b0);
    chk("stop_led_lag", led, 4'b0100);
    @(negedge clk); #1;
    chk("stop_led_off", led, 4'b0000);
    repeat (3) @(negedge clk);
    #1;
    chk("stop_hold", cnt_in, 3'd2);
    chk("stop_idle_busy", busy, 1'b0);

    // start and stop together in IDLE
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0; #1;
    chk("ss_busy", busy, 1'b0);
    chk("ss_pl", cnt_pl, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("ss_busy2", busy, 1'b0);

    // Out-of-range value injected while in DOWN
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    chk("oor_load_pl", cnt_pl, 1'b1);
    sb.push_back('{3'd0, 1'b0}); sb.push_back('{3'd1, 1'b0});
    sb.push_back('{3'd2, 1'b0}); sb.push_back('{3'd3, 1'b1});
    run_sb("run2", PRESC);
    @(negedge clk); force_req = 1'b1; force_val = 3'd5; #1;
    chk("down_dnu", cnt_dnu, 1'b1);
    @(negedge clk); force_req = 1'b0; #1;
    chk("oor_forced", cnt_in, 3'd5);
    chk("oor_no_tick", cnt_en, 1'b0);
    @(negedge clk); #1;
    chk("oor_en", cnt_en, 1'b1);
    chk("oor_pl", cnt_pl, 1'b1);
    chk("oor_pin", cnt_pin, 3'd0);
    chk("oor_led", led, 4'b0000);
    @(negedge clk); #1;
    chk("oor_reload", cnt_in, 3'd0);
    chk("oor_up_dnu", cnt_dnu, 1'b0);
    chk("oor_busy", busy, 1'b1);
    sb.push_back('{3'd0, 1'b0});
    run_sb("oor_next", PRESC - 1);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_led", led, 4'b0000);
    chk("arst_en", cnt_en, 1'b0);
    chk("arst_dnu", cnt_dnu, 1'b0);
    chk("arst_pl", cnt_pl, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    chk("restart_pl", cnt_pl, 1'b1);
    chk("restart_en", cnt_en, 1'b1);
    sb.push_back('{3'd0, 1'b0}); sb.push_back('{3'd1, 1'b0});
    run_sb("restart", PRESC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/supercar_seq.md
# supercar_seq

Sequencer for the supercar LED bar. It drives the control inputs (enable, direction, parallel load, load value) of the downstream up/down/loadable position counter and reads that counter's value back. From this it bounces the position between both ends of the bar at a prescaled step rate and decodes the position into a one-hot LED vector.

## Interface
- N_BIT, 4: width of the position counter (cnt_in, cnt_pin).
- N_LED, 16: number of LEDs. Legal range is 2 ≤ N_LED ≤ 2^N_BIT.
- PRESC, 25_000_000: clk cycles per position step. Must be ≥ 1.

Reset `rst` is asynchronous and active-high; clock is `clk`.

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle run request, sampled in IDLE
- stop  in  1  single-cycle halt request, sampled in any state
- cnt_in  in  N_BIT  current position fed back from the counter
- cnt_en  out  1  counter enable
- cnt_dnu  out  1  counter direction: 1 = down, 0 = up
- cnt_pl  out  1  counter parallel-load strobe
- cnt_pin  out  N_BIT  counter load value
- led  out  N_LED  one-hot position display, registered
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, LOAD, UP, DOWN.
- **IDLE**
  - All counter controls are 0.
  - `start`=1 and `stop`=0 → LOAD.
- **LOAD** (exactly one cycle)
  - cnt_en=1, cnt_pl=1, cnt_pin=0.
  - Next state is UP.
- **UP and DOWN**
  - cnt_en = tick. Between ticks, cnt_en=0.
  - cnt_dnu = 0 in UP, 1 in DOWN.
  - cnt_pl=0 and cnt_pin=0 unless the out-of-range rule applies.
- Bounce at the ends (decided on the tick cycle from cnt_in):
  - UP with cnt_in = N_LED-1 → emit cnt_dnu=1 on that tick and go to DOWN.
  - DOWN with cnt_in = 0 → emit cnt_dnu=0 on that tick and go to UP.
  - Resulting position sequence: 0,1,…,N_LED-1,N_LED-2,…,0,1,… No end position is repeated.
- Out-of-range: a tick in UP/DOWN with cnt_in > N_LED-1 emits cnt_en=1, cnt_pl=1, cnt_pin=0 and goes to UP.
- `stop`=1 in any non-IDLE state → IDLE on the next edge.
  - Combinational counter controls are forced to 0 in that same cycle.
  - The counter keeps its value.
  - `stop` has priority over `start` and over a tick.
- `start` outside IDLE is ignored.
- LED register:
  - In UP/DOWN: led <= 1 << cnt_in when cnt_in < N_LED, else 0.
  - In IDLE/LOAD: led <= 0.
- cnt_en, cnt_dnu, cnt_pl and cnt_pin are combinational from the registered state and prescaler, qualified by `stop`, so they are glitch-free at clk edges.

## Timing
- Reset values: state=IDLE, prescaler=0, led=0, busy=0. All counter controls are 0.
- Prescaler:
  - Counts 0..PRESC-1; tick=1 when the count equals PRESC-1, then it wraps to 0.
  - Held at 0 in IDLE and LOAD.
  - The first tick is in the PRESC-th cycle of UP. Ticks then repeat every PRESC cycles with no gap across an UP↔DOWN bounce.
  - PRESC=1 means a tick every UP/DOWN cycle.
- Start latency:
  - `start` at edge k → LOAD in cycle k+1.
  - Counter loads 0 at edge k+2.
  - led shows bit 0 from edge k+3 onward.
- led lags cnt_in by one clock.
- busy drops on the edge that enters IDLE.
- Reset mid-operation: all registers clear immediately and asynchronously. There is no partial step.

## Structure
- Package `supercar_pkg`: state encoding localparams (IDLE, LOAD, UP, DOWN) and the shared defaults for N_BIT, N_LED and PRESC.
- Sub-module `tick_gen`:
  - Parameter PRESC.
  - Ports clk, rst, clr, tick.
  - Down-counter sized with $clog2(PRESC), minimum width 1.
  - Driven with clr = (state is IDLE or LOAD) or stop.
- The FSM, control decode and LED register stay in `supercar_seq`.

## Test plan
Settings: N_BIT=3, N_LED=4, PRESC=3. The bench includes a behavioural counter model closing the loop.

- Reset asserted → led=0, busy=0, cnt_en=cnt_pl=cnt_dnu=0, cnt_pin=0.
- Pulse `start` → one LOAD cycle with cnt_pl=1, cnt_pin=0. Then a tick every 3 cycles; cnt_in runs 0,1,2,3,2,1,0,1. cnt_dnu goes to 1 on the tick at 3 and back to 0 on the tick at 0. led tracks 0001,0010,0100,1000,0100…
- `stop` while cnt_in=2 in the cycle of a tick → no cnt_en that cycle, IDLE next edge, led=0 one edge later, cnt_in holds 2.
- `start` and `stop` high in the same cycle in IDLE → stays IDLE, busy stays 0.
- Model forced to cnt_in=5 before a tick in DOWN → that tick has cnt_pl=1, cnt_en=1, cnt_pin=0; state becomes UP and led=0 while the value is out of range.
- `rst` pulsed asynchronously mid-run between edges → outputs go to 0 immediately. A subsequent `start` restarts from LOAD.
